// File: rtl/f8_mdu_pkg.sv
// ============================================================================
//  Module      : f8_mdu_pkg
//  Description : Shared opcode type and decode helpers for the iterative MDU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package f8_mdu_pkg;

    typedef enum logic [2:0] {
        MULU = 3'd0,
        MULS = 3'd1,
        MADU = 3'd2,
        MADS = 3'd3,
        DIVU = 3'd4,
        DIVS = 3'd5
    } mduop_t;

    function automatic logic is_signed(input mduop_t op);
        return (op == MULS) || (op == MADS) || (op == DIVS);
    endfunction

    function automatic logic is_div(input mduop_t op);
        return (op == DIVU) || (op == DIVS);
    endfunction

    function automatic logic is_mad(input mduop_t op);
        return (op == MADU) || (op == MADS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_signfix.sv
// ============================================================================
//  Module      : mdu_signfix
//  Description : Final-cycle sign correction, signed MAD add and flag logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_signfix #(
    parameter int WIDTH = 16
) (
    input  logic                 i_is_div,
    input  logic                 i_is_signed,
    input  logic                 i_neg_main,
    input  logic                 i_neg_rem,
    input  logic [2*WIDTH-1:0]   i_prod,
    input  logic                 i_prod_carry,
    input  logic [2*WIDTH-1:0]   i_addend,
    input  logic [WIDTH-1:0]     i_quot,
    input  logic [WIDTH-1:0]     i_rem,
    input  logic [WIDTH-1:0]     i_dividend,
    input  logic                 i_div_zero,
    input  logic                 i_div_ovf,
    output logic [WIDTH-1:0]     o_res_lo,
    output logic [WIDTH-1:0]     o_res_hi,
    output logic                 o_z,
    output logic                 o_n,
    output logic                 o_c,
    output logic                 o_o
);

    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [2*WIDTH:0]   w_sum;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = i_neg_main ? -i_prod : i_prod;
    // Addend is zero except for signed MAD; unsigned MAD was preloaded into the accumulator.
    assign w_sum      = {1'b0, w_prod_fix} + {1'b0, i_addend};
    assign w_quot_fix = i_neg_main ? -i_quot : i_quot;
    assign w_rem_fix  = i_neg_rem  ? -i_rem  : i_rem;

    always_comb begin
        o_res_lo = '0;
        o_res_hi = '0;
        o_z      = 1'b0;
        o_n      = 1'b0;
        o_c      = 1'b0;
        o_o      = 1'b0;
        if (i_is_div) begin
            if (i_div_zero) begin
                o_res_lo = '1;
                o_res_hi = i_dividend;
            end else if (i_div_ovf) begin
                o_res_lo = C_MIN;
                o_res_hi = '0;
            end else begin
                o_res_lo = w_quot_fix;
                o_res_hi = w_rem_fix;
            end
            o_z = (o_res_lo == '0);
            o_n = o_res_lo[WIDTH-1];
            o_o = i_div_zero | i_div_ovf;
        end else begin
            o_res_lo = w_sum[WIDTH-1:0];
            o_res_hi = w_sum[2*WIDTH-1:WIDTH];
            o_z      = (w_sum[2*WIDTH-1:0] == '0);
            o_n      = o_res_hi[WIDTH-1];
            o_c      = i_is_signed ? (o_res_hi != {WIDTH{o_res_lo[WIDTH-1]}})
                                   : (o_res_hi != '0);
            o_o      = w_sum[2*WIDTH] | i_prod_carry;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
//  Module      : mdu_seq
//  Description : Iterative WIDTH-bit multiply / multiply-add / divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq
    import f8_mdu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FAST_DZ = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  mduop_t             op,
    input  logic [WIDTH-1:0]   op0,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result_lo,
    output logic [WIDTH-1:0]   result_hi,
    output logic               z_out,
    output logic               n_out,
    output logic               c_out,
    output logic               o_out
);

    localparam int               C_CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] C_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [1:0]       C_ST_IDLE = 2'd0;
    localparam logic [1:0]       C_ST_CALC = 2'd1;
    localparam logic [1:0]       C_ST_FIX  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [C_CNT_W-1:0]   r_cnt;
    mduop_t               r_op;
    logic                 r_neg_main;
    logic                 r_neg_rem;
    logic                 r_dz;
    logic                 r_ovf;
    logic [2*WIDTH:0]     r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_addend;
    logic [WIDTH-1:0]     r_mq;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_div;
    logic [WIDTH-1:0]     r_dividend;
    logic                 r_done;
    logic [WIDTH-1:0]     r_res_lo;
    logic [WIDTH-1:0]     r_res_hi;
    logic [3:0]           r_flags;

    logic                 w_accept;
    logic                 w_fast_dz;
    logic                 w_sgn;
    logic                 w_neg0;
    logic                 w_neg1;
    logic [WIDTH-1:0]     w_mag0;
    logic [WIDTH-1:0]     w_mag1;
    logic [2*WIDTH-1:0]   w_op2_ext;
    logic [WIDTH+1:0]     w_shift;
    logic [WIDTH+1:0]     w_trial;
    logic [WIDTH-1:0]     w_fix_lo;
    logic [WIDTH-1:0]     w_fix_hi;
    logic                 w_fix_z;
    logic                 w_fix_n;
    logic                 w_fix_c;
    logic                 w_fix_o;

    assign w_accept  = (r_state == C_ST_IDLE) && start;
    assign w_fast_dz = (FAST_DZ != 0) && is_div(op) && (op1 == '0);
    assign w_sgn     = is_signed(op);
    assign w_neg0    = w_sgn & op0[WIDTH-1];
    assign w_neg1    = w_sgn & op1[WIDTH-1];
    assign w_mag0    = w_neg0 ? -op0 : op0;
    assign w_mag1    = w_neg1 ? -op1 : op1;
    assign w_op2_ext = w_sgn ? {{WIDTH{op2[WIDTH-1]}}, op2} : {{WIDTH{1'b0}}, op2};

    // Restoring divide step: shift in next dividend bit, keep difference if non-negative.
    assign w_shift   = {r_rem, r_mq[WIDTH-1]};
    assign w_trial   = w_shift - {2'b00, r_div};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: if (start) w_state_next = w_fast_dz ? C_ST_FIX : C_ST_CALC;
            C_ST_CALC: if (r_cnt == '0) w_state_next = C_ST_FIX;
            C_ST_FIX:  w_state_next = C_ST_IDLE;
            default:   w_state_next = C_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != C_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_op       <= MULU;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_addend   <= '0;
            r_mq       <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_dividend <= '0;
            r_done     <= 1'b0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_flags    <= '0;
        end else begin
            r_done <= (r_state == C_ST_FIX);
            if (w_accept) begin
                r_cnt      <= C_CNT_W'(WIDTH-1);
                r_op       <= op;
                r_neg_main <= w_neg0 ^ w_neg1;
                r_neg_rem  <= w_neg0;
                r_dz       <= is_div(op) && (op1 == '0);
                r_ovf      <= is_div(op) && w_sgn && (op0 == C_MIN) && (op1 == '1);
                r_acc      <= (is_mad(op) && !w_sgn) ? {1'b0, w_op2_ext} : '0;
                r_addend   <= (is_mad(op) &&  w_sgn) ? w_op2_ext : '0;
                r_mcand    <= {{WIDTH{1'b0}}, w_mag0};
                r_mq       <= is_div(op) ? w_mag0 : w_mag1;
                r_rem      <= '0;
                r_div      <= w_mag1;
                r_dividend <= op0;
            end else if (r_state == C_ST_CALC) begin
                r_cnt <= r_cnt - C_CNT_W'(1);
                if (is_div(r_op)) begin
                    if (!w_trial[WIDTH+1]) begin
                        r_rem <= w_trial[WIDTH:0];
                        r_mq  <= {r_mq[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH:0];
                        r_mq  <= {r_mq[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (r_mq[0]) r_acc <= r_acc + {1'b0, r_mcand};
                    r_mcand <= r_mcand << 1;
                    r_mq    <= r_mq >> 1;
                end
            end else if (r_state == C_ST_FIX) begin
                r_res_lo <= w_fix_lo;
                r_res_hi <= w_fix_hi;
                r_flags  <= {w_fix_z, w_fix_n, w_fix_c, w_fix_o};
            end
        end
    end

    mdu_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .i_is_div     (is_div(r_op)),
        .i_is_signed  (is_signed(r_op)),
        .i_neg_main   (r_neg_main),
        .i_neg_rem    (r_neg_rem),
        .i_prod       (r_acc[2*WIDTH-1:0]),
        .i_prod_carry (r_acc[2*WIDTH]),
        .i_addend     (r_addend),
        .i_quot       (r_mq),
        .i_rem        (r_rem[WIDTH-1:0]),
        .i_dividend   (r_dividend),
        .i_div_zero   (r_dz),
        .i_div_ovf    (r_ovf),
        .o_res_lo     (w_fix_lo),
        .o_res_hi     (w_fix_hi),
        .o_z          (w_fix_z),
        .o_n          (w_fix_n),
        .o_c          (w_fix_c),
        .o_o          (w_fix_o)
    );

    assign done      = r_done;
    assign result_lo = r_res_lo;
    assign result_hi = r_res_hi;
    assign z_out     = r_flags[3];
    assign n_out     = r_flags[2];
    assign c_out     = r_flags[1];
    assign o_out     = r_flags[0];

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// ============================================================================
//  Module      : tb_mdu_seq
//  Description : Self-checking bench for mdu_seq with an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_seq;
    import f8_mdu_pkg::*;

    localparam int W       = 16;
    localparam int FAST_DZ = 1;
    localparam int LAT     = W + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    mduop_t        op;
    logic [W-1:0]  op0, op1, op2;
    logic          busy, done;
    logic [W-1:0]  result_lo, result_hi;
    logic          z_out, n_out, c_out, o_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_seq #(
        .WIDTH   (W),
        .FAST_DZ (FAST_DZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .op0       (op0),
        .op1       (op1),
        .op2       (op2),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .z_out     (z_out),
        .n_out     (n_out),
        .c_out     (c_out),
        .o_out     (o_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: flags returned as {z, n, c, o}.
    function automatic void model(input mduop_t mop, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c, output logic [W-1:0] lo,
                                  output logic [W-1:0] hi, output logic [3:0] fl);
        logic           sg, z, n, cf, o;
        longint         sa, sb, sc, q, r;
        logic [2*W-1:0] p;
        logic [2*W:0]   sum;
        logic [W-1:0]   minv;
        minv = '0;
        minv[W-1] = 1'b1;
        sg = (mop == MULS) || (mop == MADS) || (mop == DIVS);
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        sc = sg ? longint'($signed(c)) : longint'(c);
        lo = '0; hi = '0; o = 1'b0; cf = 1'b0;
        if (mop == DIVU || mop == DIVS) begin
            if (b == '0) begin
                lo = '1; hi = a; o = 1'b1;
            end else if (sg && a == minv && b == '1) begin
                lo = minv; hi = '0; o = 1'b1;
            end else begin
                q = sa / sb;
                r = sa % sb;
                lo = q[W-1:0];
                hi = r[W-1:0];
            end
            z = (lo == '0);
            n = lo[W-1];
        end else begin
            q = sa * sb;
            p = q[2*W-1:0];
            if (mop == MADU || mop == MADS) sum = {1'b0, p} + {1'b0, sc[2*W-1:0]};
            else                            sum = {1'b0, p};
            lo = sum[W-1:0];
            hi = sum[2*W-1:W];
            o  = sum[2*W];
            z  = (sum[2*W-1:0] == '0);
            n  = hi[W-1];
            cf = sg ? (hi != {W{lo[W-1]}}) : (hi != '0);
        end
        fl = {z, n, cf, o};
    endfunction

    // Cycle-level model: acceptance, completion cycle and held results.
    int            k   = 0;
    int            due = 0;
    logic          pend  = 1'b0;
    logic          armed = 1'b0;
    mduop_t        m_op  = MULU;
    logic [W-1:0]  m_a = '0, m_b = '0, m_c = '0;
    logic [W-1:0]  e_lo = '0, e_hi = '0;
    logic [3:0]    e_fl = '0;

    always @(negedge clk) begin : compare
        logic exp_done, exp_busy;
        exp_done = pend && (k == due);
        exp_busy = pend && (k < due);
        if (exp_done) model(m_op, m_a, m_b, m_c, e_lo, e_hi, e_fl);
        if (armed) begin
            check("cyc_done", {31'd0, done}, {31'd0, exp_done});
            check("cyc_busy", {31'd0, busy}, {31'd0, exp_busy});
            check("cyc_lo", {16'd0, result_lo}, {16'd0, e_lo});
            check("cyc_hi", {16'd0, result_hi}, {16'd0, e_hi});
            check("cyc_flags", {28'd0, z_out, n_out, c_out, o_out}, {28'd0, e_fl});
        end
        if (reset) begin
            pend = 1'b0;
            e_lo = '0; e_hi = '0; e_fl = '0;
            armed = 1'b1;
        end else if (start && !exp_busy) begin
            pend = 1'b1;
            m_op = op; m_a = op0; m_b = op1; m_c = op2;
            due  = k + 1 + (((op == DIVU || op == DIVS) && op1 == '0 && FAST_DZ != 0) ? 1 : W + 1);
        end
        k++;
    end

    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
    endtask

    task automatic run_op(input string name, input mduop_t o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] xlo, input logic [W-1:0] xhi,
                          input logic [3:0] xfl, input int xlat);
        int n;
        @(posedge clk); #2;
        start = 1'b1; op = o; op0 = a; op1 = b; op2 = c;
        @(posedge clk); #2;
        start = 1'b0;
        op  = mduop_t'($urandom_range(0, 5));
        op0 = W'($urandom); op1 = W'($urandom); op2 = W'($urandom);
        wait_done(n);
        check({name, "_lat"}, n, xlat);
        check({name, "_lo"}, {16'd0, result_lo}, {16'd0, xlo});
        check({name, "_hi"}, {16'd0, result_hi}, {16'd0, xhi});
        check({name, "_flags"}, {28'd0, z_out, n_out, c_out, o_out}, {28'd0, xfl});
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within budget");
        $fatal(1);
    end

    initial begin : stim
        int n;
        reset = 1'b1; start = 1'b0; op = MULU; op0 = '0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_lo", {16'd0, result_lo}, 32'd0);
        check("rst_hi", {16'd0, result_hi}, 32'd0);
        reset = 1'b0;

        run_op("mulu_max",  MULU, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 4'b0110, LAT);
        run_op("mads",      MADS, 16'hFFFD, 16'h0005, 16'h0004, 16'hFFF5, 16'hFFFF, 4'b0100, LAT);
        run_op("divs_neg",  DIVS, 16'hFFF9, 16'h0002, 16'h0000, 16'hFFFD, 16'hFFFF, 4'b0100, LAT);
        run_op("divs_ovf",  DIVS, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 4'b0101, LAT);
        run_op("divu_dz",   DIVU, 16'h1234, 16'h0000, 16'h0000, 16'hFFFF, 16'h1234, 4'b0101, 2);
        run_op("mads_cy",   MADS, 16'hFFFF, 16'h0001, 16'h0002, 16'h0001, 16'h0000, 4'b0001, LAT);
        run_op("muls_min",  MULS, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h4000, 4'b0010, LAT);
        run_op("divs_nd",   DIVS, 16'h0007, 16'hFFFE, 16'h0000, 16'hFFFD, 16'h0001, 4'b0100, LAT);
        run_op("mulu_zero", MULU, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b1000, LAT);
        run_op("madu_max",  MADU, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 4'b0110, LAT);

        // start held high across two operations
        @(posedge clk); #2;
        start = 1'b1; op = MULU; op0 = 16'h0003; op1 = 16'h0005; op2 = 16'h0000;
        @(posedge clk); #2;
        op = DIVU; op0 = 16'd100; op1 = 16'd7;
        wait_done(n);
        check("b2b_lat1", n, LAT);
        check("b2b_lo1", {16'd0, result_lo}, 32'h000F);
        @(posedge clk); #2;
        start = 1'b0; op0 = 16'hDEAD; op1 = 16'hBEEF;
        wait_done(n);
        check("b2b_lat2", n, LAT);
        check("b2b_lo2", {16'd0, result_lo}, 32'h000E);
        check("b2b_hi2", {16'd0, result_hi}, 32'h0002);

        // start pulse while busy must be ignored
        @(posedge clk); #2;
        start = 1'b1; op = MULS; op0 = 16'hFFFE; op1 = 16'h0003;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1; op = DIVU; op0 = 16'h0005; op1 = 16'h0000;
        @(posedge clk); #2;
        start = 1'b0;
        n = 5;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        check("ign_lat", n, LAT);
        check("ign_lo", {16'd0, result_lo}, 32'hFFFA);
        check("ign_hi", {16'd0, result_hi}, 32'hFFFF);

        run_op("divs_dz",   DIVS, 16'h1234, 16'h0000, 16'h0000, 16'hFFFF, 16'h1234, 4'b0101, 2);

        // reset in the middle of a divide
        @(posedge clk); #2;
        start = 1'b1; op = DIVU; op0 = 16'h1000; op1 = 16'h0003;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_lo", {16'd0, result_lo}, 32'd0);
        check("mid_rst_hi", {16'd0, result_hi}, 32'd0);
        check("mid_rst_flags", {28'd0, z_out, n_out, c_out, o_out}, 32'd0);
        repeat (25) @(posedge clk);
        #2;

        run_op("post_rst",  DIVU, 16'h1000, 16'h0003, 16'h0000, 16'h0555, 16'h0001, 4'b0000, LAT);

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
